// File: rtl/neptune_demux_pkg.sv
// Shared definitions for the Neptune I 1-to-4 demultiplexer.
// Contents: channel index constants, channel count, and a select-to-one-hot
// decoder used to turn the 2-bit destination select into per-slot strobes.
package neptune_demux_pkg;

   localparam int NUM_CH = 4;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   // Decode a destination select into a one-hot slot mask (bit0=A ... bit3=D).
   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
      logic [NUM_CH-1:0] oh;
      case (sel)
         CH_A:    oh = 4'b0001;
         CH_B:    oh = 4'b0010;
         CH_C:    oh = 4'b0100;
         CH_D:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output slot of the 1-to-4 demultiplexer.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - synchronous clear of the valid flag (data is kept)
//   load         - capture load_data this edge and mark the slot valid
//   load_data    - word to capture
//   ready        - downstream consumer ready
//   valid, data  - registered slot outputs
module demux_out_slot
   import neptune_demux_pkg::*;
#(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [width-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [width-1:0] data
);

   logic             valid_r;
   logic [width-1:0] data_r;

   // Slot state: flush beats load, load beats drain; data is only written on
   // load so a drained or flushed slot keeps showing its last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {width{1'b0}};
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= load_data;
      end else if (ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;

endmodule

// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer (Neptune I v3.0).
// Routes each accepted input word to one of four single-entry slots A..D
// selected by in_sel, or to all four at once when in_bcast is set.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous clear of all slot valids, blocks input
//   in_valid/in_ready     - input handshake (in_ready is combinational)
//   in_sel, in_bcast      - destination select / broadcast request
//   in_data               - input word
//   out_valid/out_ready   - per-slot handshake, bit0=A ... bit3=D
//   a_out..d_out          - registered slot data
module demux_1_to_4_reg
   import neptune_demux_pkg::*;
#(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic             in_bcast,
   input  logic [width-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [width-1:0] a_out,
   output logic [width-1:0] b_out,
   output logic [width-1:0] c_out,
   output logic [width-1:0] d_out
);

   logic [NUM_CH-1:0] can_load_s;
   logic [NUM_CH-1:0] target_s;
   logic [NUM_CH-1:0] load_s;
   logic              in_ready_s;
   logic [width-1:0]  slot_data_s [NUM_CH];

   // A slot can take a word when empty or when its current word leaves this cycle.
   assign can_load_s = ~out_valid | out_ready;

   // Handshake and load strobes. Broadcast needs every slot free so that it is
   // never split across cycles. Strobes are gated by in_valid, so an unknown
   // select while idle cannot disturb any slot.
   always_comb begin
      target_s   = {NUM_CH{1'b0}};
      in_ready_s = 1'b0;
      load_s     = {NUM_CH{1'b0}};

      if (in_bcast) begin
         target_s = {NUM_CH{1'b1}};
      end else begin
         target_s = sel_onehot(in_sel);
      end

      if (!rst_n || flush) begin
         in_ready_s = 1'b0;
      end else if (in_bcast) begin
         in_ready_s = &can_load_s;
      end else begin
         in_ready_s = |(can_load_s & target_s);
      end

      if (in_valid && in_ready_s) begin
         load_s = target_s;
      end else begin
         load_s = {NUM_CH{1'b0}};
      end
   end

   assign in_ready = in_ready_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_out_slot #(
         .width(width)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .load      (load_s[i]),
         .load_data (in_data),
         .ready     (out_ready[i]),
         .valid     (out_valid[i]),
         .data      (slot_data_s[i])
      );
   end

   assign a_out = slot_data_s[CH_A];
   assign b_out = slot_data_s[CH_B];
   assign c_out = slot_data_s[CH_C];
   assign d_out = slot_data_s[CH_D];

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
// Self-checking bench for demux_1_to_4_reg: directed scenarios plus a random
// stream, compared against a slot-level reference model kept in the bench.
module tb_demux_1_to_4_reg;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic        in_bcast;
   logic [15:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] a_out, b_out, c_out, d_out;
   logic [15:0] obs [4];

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: which slots hold a word, and the word each slot shows.
   logic [3:0]  exp_valid;
   logic [15:0] exp_data [4];

   demux_1_to_4_reg #(.width(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .in_sel(in_sel), .in_bcast(in_bcast),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs[0] = a_out;
      obs[1] = b_out;
      obs[2] = c_out;
      obs[3] = d_out;
   end

   function automatic void model_reset();
      exp_valid = 4'b0000;
      for (int i = 0; i < 4; i++) exp_data[i] = 16'h0000;
   endfunction

   // Expected input readiness from the slot occupancy in the model.
   function automatic logic exp_ready();
      if (!rst_n || flush) return 1'b0;
      if (in_bcast) begin
         for (int i = 0; i < 4; i++)
            if (exp_valid[i] && !out_ready[i]) return 1'b0;
         return 1'b1;
      end
      return !exp_valid[in_sel] || out_ready[in_sel];
   endfunction

   // Advance one clock edge and apply the slot rules to the model.
   task automatic tick();
      logic acc;
      acc = in_valid && exp_ready();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (flush) begin
            exp_valid[i] = 1'b0;
         end else if (acc && (in_bcast || in_sel == 2'(i))) begin
            exp_valid[i] = 1'b1;
            exp_data[i]  = in_data;
         end else if (exp_valid[i] && out_ready[i]) begin
            exp_valid[i] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic b,
                        input logic [15:0] d, input logic [3:0] r, input logic f);
      in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = r; flush = f;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 2'd0, 1'b0, 16'h1111, 4'b0000, 1'b0); tick();
      drive(1'b1, 2'd2, 1'b0, 16'h3333, 4'b0000, 1'b0); tick();
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 1'b0);
      tests_run++;
      if (out_valid !== 4'b0101) begin
         tests_failed++; $display("FAIL reset_prefill out_valid got %b want 0101", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if (out_valid !== 4'b0000) begin
         tests_failed++; $display("FAIL reset_valid got %b want 0000", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs[i] !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_data slot %0d got %h want 0000", i, obs[i]);
         end
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1 rst_n = 1'b1; #1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s); #1;
         tests_run++;
         if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset_ready sel %0d got %b want 1", s, in_ready);
         end
      end
   endtask

   task automatic test_single_route();
      drive(1'b1, 2'd2, 1'b0, 16'hBEEF, 4'b0000, 1'b0);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL route_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0100, 1'b0);
      tests_run++;
      if (out_valid !== 4'b0100 || c_out !== 16'hBEEF) begin
         tests_failed++; $display("FAIL route_load got %b/%h want 0100/beef", out_valid, c_out);
      end
      tick();
      tests_run++;
      if (out_valid !== 4'b0000 || c_out !== 16'hBEEF) begin
         tests_failed++; $display("FAIL route_drain got %b/%h want 0000/beef", out_valid, c_out);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 2'd1, 1'b0, 16'h1234, 4'b0000, 1'b0); tick();
      drive(1'b1, 2'd1, 1'b0, 16'h5678, 4'b0000, 1'b0);
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL bp_blocked_ready got %b want 0", in_ready);
      end
      tick();
      tests_run++;
      if (b_out !== 16'h1234 || out_valid !== 4'b0010) begin
         tests_failed++; $display("FAIL bp_hold got %b/%h want 0010/1234", out_valid, b_out);
      end
      drive(1'b1, 2'd0, 1'b0, 16'h5678, 4'b0000, 1'b0);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL bp_other_ready got %b want 1", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 4'b0011 || a_out !== 16'h5678 || b_out !== 16'h1234) begin
         tests_failed++;
         $display("FAIL bp_other_load got %b/%h/%h want 0011/5678/1234", out_valid, a_out, b_out);
      end
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b0); tick();
   endtask

   task automatic test_throughput();
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, (k % 2 == 1) ? 2'd0 : 2'd3, 1'b0, 16'(k), 4'b1111, 1'b0);
         tests_run++;
         if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL tput_ready word %0d got %b want 1", k, in_ready);
         end
         tick();
         tests_run++;
         if ((k % 2 == 1 && (a_out !== 16'(k) || out_valid !== 4'b0001)) ||
             (k % 2 == 0 && (d_out !== 16'(k) || out_valid !== 4'b1000))) begin
            tests_failed++;
            $display("FAIL tput_word %0d got valid %b a %h d %h", k, out_valid, a_out, d_out);
         end
      end
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b0); tick();
   endtask

   task automatic test_broadcast();
      drive(1'b1, 2'd3, 1'b0, 16'h0D0D, 4'b0000, 1'b0); tick();
      drive(1'b1, 2'd1, 1'b1, 16'hA5A5, 4'b0111, 1'b0);
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL bcast_blocked_ready got %b want 0", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 4'b1000 || d_out !== 16'h0D0D || a_out === 16'hA5A5) begin
         tests_failed++; $display("FAIL bcast_no_partial got %b a %h d %h", out_valid, a_out, d_out);
      end
      drive(1'b1, 2'd1, 1'b1, 16'hA5A5, 4'b1111, 1'b0);
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL bcast_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 1'b0);
      tests_run++;
      if (out_valid !== 4'b1111) begin
         tests_failed++; $display("FAIL bcast_valid got %b want 1111", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (obs[i] !== 16'hA5A5) begin
            tests_failed++; $display("FAIL bcast_data slot %0d got %h want a5a5", i, obs[i]);
         end
      end
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b0); tick();
   endtask

   task automatic test_flush();
      drive(1'b1, 2'd0, 1'b0, 16'h00AA, 4'b0000, 1'b0); tick();
      drive(1'b1, 2'd1, 1'b0, 16'h00BB, 4'b0000, 1'b0); tick();
      drive(1'b1, 2'd0, 1'b0, 16'hDEAD, 4'b0011, 1'b1);
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++; $display("FAIL flush_ready got %b want 0", in_ready);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      tests_run++;
      if (out_valid !== 4'b0000 || a_out !== 16'h00AA || b_out !== 16'h00BB) begin
         tests_failed++;
         $display("FAIL flush_clear got %b/%h/%h want 0000/00aa/00bb", out_valid, a_out, b_out);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
               ($urandom_range(0, 15) == 0));
         tests_run++;
         if (in_ready !== exp_ready()) begin
            tests_failed++; $display("FAIL rand_ready cyc %0d got %b want %b", n, in_ready, exp_ready());
         end
         tick();
         tests_run++;
         if (out_valid !== exp_valid) begin
            tests_failed++; $display("FAIL rand_valid cyc %0d got %b want %b", n, out_valid, exp_valid);
         end
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs[i] !== exp_data[i]) begin
               tests_failed++;
               $display("FAIL rand_data cyc %0d slot %0d got %h want %h", n, i, obs[i], exp_data[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
      in_bcast = 1'b0; in_data = 16'h0000; out_ready = 4'b0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; #1;
      test_reset();
      test_single_route();
      test_backpressure();
      test_throughput();
      test_broadcast();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
